auth_tag_checker: RTL and testbench

AUTH_TAG_CHECKER -- requirements
Module: auth_tag_checker

---
 rtl/auth_tag_checker.sv | 174 +++++++++++++++++
 tb/tb_auth_tag_checker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_tag_checker.sv
// Challenge/response tag checker: starts a PRF run on a nonce, then compares 16 host bytes
// against the PRF tag in constant time. Optional lockout after repeated failures: AUTH_LOCKOUT_EN.
module auth_tag_checker #(
  parameter int MAX_FAILS  = 3,
  parameter int RX_TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         challenge_go,
  input  logic [127:0] nonce_in,
  output logic [127:0] prf_nonce,
  output logic         prf_start,
  input  logic         prf_ready,
  input  logic         prf_valid,
  input  logic [127:0] prf_tag,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         busy,
  output logic         auth_done,
  output logic         auth_pass,
  output logic         locked,
  output logic [2:0]   dbg_state_o
);

  // Handshakes: prf_start is a single-cycle request qualified by prf_ready; prf_valid is a
  // single-cycle pulse; a response byte moves on any rising edge where rx_valid && rx_ready.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_TAG = 3'd2,
    S_RX       = 3'd3,
    S_COMPARE  = 3'd4
`ifdef AUTH_LOCKOUT_EN
    , S_LOCKED = 3'd5
`endif
  } state_t;

  // auth_done is registered, so the timeout is decided one cycle early; the strobe then lands
  // exactly RX_TIMEOUT cycles after the last accepted byte.
  localparam logic [23:0] TMO_FIRE = (RX_TIMEOUT > 1) ? 24'(RX_TIMEOUT - 2) : 24'd0;

  state_t        state_q, state_d;
  logic [127:0]  nonce_q, nonce_d;
  logic [127:0]  tag_q, tag_d;
  logic [7:0]    diff_q, diff_d;
  logic [3:0]    idx_q, idx_d;
  logic [23:0]   tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fin, fin_pass;
`ifdef AUTH_LOCKOUT_EN
  localparam logic [3:0] MAX_F = 4'(MAX_FAILS);
  logic [3:0]    fail_q, fail_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      nonce_q <= '0;
      tag_q   <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      tag_q   <= tag_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef AUTH_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    tag_d    = tag_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    fin      = 1'b0;
    fin_pass = 1'b0;
`ifdef AUTH_LOCKOUT_EN
    fail_d   = fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (challenge_go) begin
          nonce_d = nonce_in;
          pass_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (prf_ready) state_d = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        if (prf_valid) begin
          tag_d   = prf_tag;
          idx_d   = '0;
          diff_d  = '0;
          tmo_d   = '0;
          state_d = S_RX;
        end
      end
      S_RX: begin
        // The tag shifts left per byte so the expected byte is always the top one (MSB-first).
        if (rx_valid) begin
          diff_d = diff_q | (rx_data ^ tag_q[127:120]);
          tag_d  = {tag_q[119:0], 8'h00};
          idx_d  = idx_q + 4'd1;
          tmo_d  = '0;
          if (idx_q == 4'd15) state_d = S_COMPARE;
        end else if (tmo_q == TMO_FIRE) begin
          fin      = 1'b1;
          fin_pass = 1'b0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_COMPARE: begin
        fin      = 1'b1;
        fin_pass = (diff_q == 8'h00);
      end
      default: state_d = state_q;
    endcase

    if (fin) begin
      done_d  = 1'b1;
      pass_d  = fin_pass;
      tag_d   = '0;
      diff_d  = '0;
      idx_d   = '0;
      tmo_d   = '0;
      state_d = S_IDLE;
`ifdef AUTH_LOCKOUT_EN
      if (fin_pass) begin
        fail_d = '0;
      end else if (fail_q < MAX_F) begin
        fail_d = fail_q + 4'd1;
        if (fail_q + 4'd1 >= MAX_F) state_d = S_LOCKED;
      end
`endif
    end
  end

  assign prf_nonce   = nonce_q;
  assign prf_start   = (state_q == S_START) && prf_ready;
  assign rx_ready    = (state_q == S_RX);
  assign auth_done   = done_q;
  assign auth_pass   = pass_q;
  assign dbg_state_o = state_q;
`ifdef AUTH_LOCKOUT_EN
  assign busy   = (state_q != S_IDLE) && (state_q != S_LOCKED);
  assign locked = (state_q == S_LOCKED);
`else
  assign busy   = (state_q != S_IDLE);
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_auth_tag_checker.sv
// Bench for auth_tag_checker: random and directed authentications checked against a
// response-equals-tag reference model with a fail counter and lockout flag.
module tb_auth_tag_checker;

  localparam int MAX_FAILS  = 3;
  localparam int RX_TIMEOUT = 100;
`ifdef AUTH_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam logic [127:0] REF_TAG = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         challenge_go = 1'b0;
  logic [127:0] nonce_in = '0;
  logic [127:0] prf_nonce;
  logic         prf_start;
  logic         prf_ready = 1'b1;
  logic         prf_valid = 1'b0;
  logic [127:0] prf_tag = '0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready, busy, auth_done, auth_pass, locked;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int fail_model = 0;

  auth_tag_checker #(.MAX_FAILS(MAX_FAILS), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .challenge_go(challenge_go), .nonce_in(nonce_in),
    .prf_nonce(prf_nonce), .prf_start(prf_start), .prf_ready(prf_ready),
    .prf_valid(prf_valid), .prf_tag(prf_tag), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .auth_done(auth_done), .auth_pass(auth_pass),
    .locked(locked), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; challenge_go = 1'b0; rx_valid = 1'b0; prf_valid = 1'b0; prf_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fail_model = 0;
    @(negedge clk);
  endtask

  task automatic challenge(input logic [127:0] nonce);
    @(negedge clk);
    nonce_in = nonce; challenge_go = 1'b1;
    @(negedge clk);
    challenge_go = 1'b0; nonce_in = rand128();
  endtask

  task automatic serve_prf(input logic [127:0] tag, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (!prf_start && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (prf_start !== 1'b1) begin
      $display("FAIL prf_start_wait: got %b want 1 within 40 cycles", prf_start);
      return;
    end
    n_pass++;
    ok = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    prf_tag = tag; prf_valid = 1'b1;
    @(negedge clk);
    prf_valid = 1'b0; prf_tag = rand128();
  endtask

  // Leaves the caller 1 ns after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && t < 40) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      n_checks++;
      $display("FAIL rx_ready_wait: got %b want 1 within 40 cycles", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic check_result(input string name, input bit exp_pass, input int exp_k);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < RX_TIMEOUT + 20) begin
      @(negedge clk); k++;
      if (auth_done) seen = 1'b1;
    end
    n_checks++;
    if (!seen || k != exp_k) $display("FAIL %s_latency: got %0d want %0d cycles", name, seen ? k : -1, exp_k);
    else n_pass++;
    n_checks++;
    if (auth_pass !== exp_pass) $display("FAIL %s_pass: got %b want %b", name, auth_pass, exp_pass);
    else n_pass++;
    if (exp_pass) fail_model = 0;
    else if (fail_model < MAX_FAILS) fail_model++;
    n_checks++;
    if (locked !== (LOCK_EN && fail_model == MAX_FAILS))
      $display("FAIL %s_locked: got %b want %b", name, locked, LOCK_EN && fail_model == MAX_FAILS);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (auth_done !== 1'b0 || auth_pass !== exp_pass || busy !== 1'b0)
      $display("FAIL %s_after: got done=%b pass=%b busy=%b want 0 %b 0", name, auth_done, auth_pass, busy, exp_pass);
    else n_pass++;
  endtask

  task automatic run_auth(input string name, input logic [127:0] tag, input logic [127:0] resp,
                          input int gap_max);
    logic [127:0] nonce = rand128();
    logic [127:0] r = resp;
    bit ok;
    challenge(nonce);
    n_checks++;
    if (prf_nonce !== nonce || busy !== 1'b1 || auth_pass !== 1'b0)
      $display("FAIL %s_start: got nonce=%h busy=%b pass=%b want %h 1 0", name, prf_nonce, busy, auth_pass, nonce);
    else n_pass++;
    serve_prf(tag, ok);
    if (!ok) return;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(r[127:120]);
      r = r << 8;
    end
    check_result(name, resp == tag, 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({prf_start, rx_ready, busy, auth_done, auth_pass, locked} !== 6'b0 || prf_nonce !== '0)
      $display("FAIL reset_outputs: got %b nonce=%h want all 0", {prf_start, rx_ready, busy, auth_done, auth_pass, locked}, prf_nonce);
    else n_pass++;
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_ready: got rx_ready=%b busy=%b want 0 0", rx_ready, busy);
    else n_pass++;
    rx_valid = 1'b0;
  endtask

  task automatic test_pass();
    run_auth("pass", REF_TAG, REF_TAG, 0);
    run_auth("pass_gaps", REF_TAG, REF_TAG, 3);
  endtask

  task automatic test_mismatch();
    run_auth("bad_last", REF_TAG, REF_TAG ^ 128'h01, 0);
    run_auth("bad_first", REF_TAG, REF_TAG ^ {8'h80, 120'h0}, 0);
    run_auth("clear_fails", REF_TAG, REF_TAG, 1);
  endtask

  task automatic test_backpressure();
    logic [127:0] tag = rand128();
    logic [127:0] r = tag;
    int starts = 0;
    prf_ready = 1'b0;
    challenge(rand128());
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      if (prf_start) starts++;
      if (rx_ready) starts += 100;
      @(negedge clk);
    end
    n_checks++;
    if (starts != 0) $display("FAIL bp_hold: got %0d want 0 (starts + 100*ready)", starts);
    else n_pass++;
    prf_ready = 1'b1;
    #1;
    n_checks++;
    if (prf_start !== 1'b1) $display("FAIL bp_start: got %b want 1", prf_start);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (prf_start || rx_ready) starts++;
      @(negedge clk);
    end
    n_checks++;
    if (starts != 0) $display("FAIL bp_wait_tag: got %0d want 0 extra start/ready cycles", starts);
    else n_pass++;
    rx_valid = 1'b0;
    prf_tag = tag; prf_valid = 1'b1;
    @(negedge clk);
    prf_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send_byte(r[127:120]);
      r = r << 8;
    end
    check_result("bp", 1'b1, 2);
  endtask

  task automatic test_timeout();
    logic [127:0] tag = rand128();
    logic [127:0] r = tag;
    bit ok;
    challenge(rand128());
    serve_prf(tag, ok);
    if (!ok) return;
    for (int k = 0; k < 5; k++) begin
      send_byte(r[127:120]);
      r = r << 8;
    end
    check_result("timeout", 1'b0, RX_TIMEOUT);
  endtask

  task automatic test_reset_mid_rx();
    logic [127:0] tag = rand128();
    logic [127:0] r = tag;
    int dones = 0;
    bit ok;
    challenge(rand128());
    serve_prf(tag, ok);
    if (!ok) return;
    for (int k = 0; k < 8; k++) begin
      send_byte(r[127:120]);
      r = r << 8;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({prf_start, rx_ready, busy, auth_done, auth_pass, locked} !== 6'b0 || prf_nonce !== '0)
      $display("FAIL midrx_outputs: got %b nonce=%h want all 0", {prf_start, rx_ready, busy, auth_done, auth_pass, locked}, prf_nonce);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fail_model = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (auth_done) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL midrx_no_done: got %0d want 0 strobes", dones);
    else n_pass++;
    run_auth("after_rst", tag, tag, 2);
  endtask

  task automatic test_lockout();
    int starts = 0;
    for (int i = 0; i < MAX_FAILS; i++) begin
      logic [127:0] tag = rand128();
      run_auth("lock_fail", tag, ~tag, 1);
    end
    challenge(rand128());
    for (int i = 0; i < 20; i++) begin
      if (prf_start) starts++;
      @(negedge clk);
    end
    n_checks++;
    if (starts != (LOCK_EN ? 0 : 1)) $display("FAIL lock_go_ignored: got %0d want %0d prf_start", starts, LOCK_EN ? 0 : 1);
    else n_pass++;
    do_reset();
    n_checks++;
    if (locked !== 1'b0 || busy !== 1'b0) $display("FAIL lock_rst: got locked=%b busy=%b want 0 0", locked, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [127:0] tag = rand128();
      logic [127:0] resp = tag;
      if (LOCK_EN && fail_model == MAX_FAILS) do_reset();
      if ($urandom_range(0, 1) == 0)
        resp = tag ^ (128'($urandom_range(1, 255)) << (8 * $urandom_range(0, 15)));
      run_auth("random", tag, resp, 3);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_backpressure();
    test_timeout();
    test_reset_mid_rx();
    test_lockout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
